// File: rtl/cluster_dma_frontend_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cluster_dma_frontend_pkg
//  Purpose  : Shared definitions for the cluster DMA frontend register file:
//             register byte offsets, conf bit positions, the backend
//             descriptor type and its builder, and a byte-enable merge helper.
//  Revision : 1.0 - initial release
// ============================================================================
package cluster_dma_frontend_pkg;

    // Register byte offsets, decoded from the low address byte
    localparam logic [7:0] OFF_SRC_LO     = 8'h00;
    localparam logic [7:0] OFF_SRC_HI     = 8'h04;
    localparam logic [7:0] OFF_DST_LO     = 8'h08;
    localparam logic [7:0] OFF_DST_HI     = 8'h0C;
    localparam logic [7:0] OFF_NUM_BYTES  = 8'h10;
    localparam logic [7:0] OFF_CONF       = 8'h14;
    localparam logic [7:0] OFF_SRC_STRIDE = 8'h18;
    localparam logic [7:0] OFF_DST_STRIDE = 8'h1C;
    localparam logic [7:0] OFF_NUM_REPS   = 8'h20;
    localparam logic [7:0] OFF_LAUNCH     = 8'h24;
    localparam logic [7:0] OFF_STATUS     = 8'h28;
    localparam logic [7:0] OFF_DONE_ID    = 8'h2C;

    // conf register layout
    localparam int unsigned CONF_DECOUPLE  = 0;
    localparam int unsigned CONF_DEBURST   = 1;
    localparam int unsigned CONF_SERIALIZE = 2;
    localparam int unsigned CONF_IRQ_EN    = 3;
    localparam int unsigned CONF_WIDTH     = 4;
    localparam logic [CONF_WIDTH-1:0] CONF_RESET = 4'b0101;

    // Backend descriptor; addresses are carried at full 64-bit width so the
    // same type serves both 32- and 64-bit address configurations.
    typedef struct packed {
        logic [31:0] num_bytes;
        logic [63:0] dst_addr;
        logic [63:0] src_addr;
        logic [31:0] src_stride;
        logic [31:0] dst_stride;
        logic [31:0] num_reps;
        logic        is_2d;
        logic        decouple;
        logic        deburst;
        logic        serialize;
    } dma_descr_t;

    function automatic dma_descr_t build_descr(
        input logic [63:0]           src_addr,
        input logic [63:0]           dst_addr,
        input logic [31:0]           num_bytes,
        input logic [31:0]           src_stride,
        input logic [31:0]           dst_stride,
        input logic [31:0]           num_reps,
        input logic [CONF_WIDTH-1:0] conf
    );
        dma_descr_t d;
        d.num_bytes  = num_bytes;
        d.dst_addr   = dst_addr;
        d.src_addr   = src_addr;
        d.src_stride = src_stride;
        d.dst_stride = dst_stride;
        d.num_reps   = num_reps;
        // A single repetition is a plain 1D transfer
        d.is_2d      = (num_reps > 32'd1);
        d.decouple   = conf[CONF_DECOUPLE];
        d.deburst    = conf[CONF_DEBURST];
        d.serialize  = conf[CONF_SERIALIZE];
        return d;
    endfunction

    function automatic logic [31:0] apply_be(
        input logic [31:0] old_val,
        input logic [31:0] wdata,
        input logic [3:0]  be
    );
        logic [31:0] r;
        r = old_val;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[b*8 +: 8] = wdata[b*8 +: 8];
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_v3.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_v3
//  Purpose  : Synchronous FIFO, interface-compatible subset of the
//             common_cells fifo_v3 (no fall-through mode). DEPTH must be a
//             power of two >= 2.
//  Ports    : clk_i, rst_ni (async, active-low), flush_i, testmode_i,
//             full_o, empty_o, usage_o (fill level, wraps to 0 when full),
//             data_i/push_i (write side), data_o/pop_i (read side).
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_v3 #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 8,
    parameter type         dtype      = logic [DATA_WIDTH-1:0],
    parameter int unsigned ADDR_DEPTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  testmode_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [ADDR_DEPTH-1:0] usage_o,
    input  dtype                  data_i,
    input  logic                  push_i,
    output dtype                  data_o,
    input  logic                  pop_i
);

    localparam logic [ADDR_DEPTH-1:0] PTR_ONE  = ADDR_DEPTH'(1);
    localparam logic [ADDR_DEPTH:0]   FULL_CNT = (ADDR_DEPTH + 1)'(DEPTH);

    dtype                  mem [DEPTH];
    logic [ADDR_DEPTH-1:0] rd_ptr;
    logic [ADDR_DEPTH-1:0] wr_ptr;
    logic [ADDR_DEPTH:0]   cnt;
    logic                  do_push;
    logic                  do_pop;
    logic                  unused_testmode;

    assign unused_testmode = testmode_i;

    assign full_o  = (cnt == FULL_CNT);
    assign empty_o = (cnt == '0);
    assign usage_o = cnt[ADDR_DEPTH-1:0];
    assign data_o  = mem[rd_ptr];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            cnt <= cnt + {{ADDR_DEPTH{1'b0}}, do_push} - {{ADDR_DEPTH{1'b0}}, do_pop};
        end
    end

    // Storage needs no reset: only entries between the pointers are visible
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= data_i;
    end

endmodule
`default_nettype wire

// File: rtl/cluster_dma_frontend_queue_regs.sv
`default_nettype none
// ============================================================================
//  Module   : cluster_dma_frontend_queue_regs
//  Purpose  : TCDM-mapped register frontend of the cluster DMA. Software fills
//             shadow registers, then reads the launch register to queue a
//             descriptor for the backend and obtain its transfer ID.
//  Ports    : clk_i, rst_i (async, active-high)
//             ctrl_*  : TCDM slave (req/type/be/add/data in; gnt/valid/data out)
//             be_*    : descriptor queue handshake plus backend busy/done
//             irq_o   : completion interrupt pulse
//  Revision : 1.0 - initial release
// ============================================================================
module cluster_dma_frontend_queue_regs
    import cluster_dma_frontend_pkg::*;
#(
    parameter type         transf_descr_t = dma_descr_t,
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned FifoDepth      = 4,
    parameter int unsigned IdWidth        = 28
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          ctrl_req_i,
    input  logic          ctrl_type_i,
    input  logic [3:0]    ctrl_be_i,
    input  logic [31:0]   ctrl_add_i,
    input  logic [31:0]   ctrl_data_i,
    output logic          ctrl_gnt_o,
    output logic          ctrl_valid_o,
    output logic [31:0]   ctrl_data_o,
    output logic          be_valid_o,
    input  logic          be_ready_i,
    output transf_descr_t transf_descr_o,
    input  logic          be_busy_i,
    input  logic          be_done_i,
    output logic          irq_o
);

    localparam bit                   HAS_HI  = (AddrWidth == 64);
    localparam int unsigned          USAGE_W = $clog2(FifoDepth);
    localparam logic [IdWidth-1:0]   ID_ONE  = IdWidth'(1);
    localparam logic [IdWidth-1:0]   ID_MAX  = {IdWidth{1'b1}};

    logic [63:0]           src_addr;
    logic [63:0]           dst_addr;
    logic [31:0]           num_bytes;
    logic [31:0]           src_stride;
    logic [31:0]           dst_stride;
    logic [31:0]           num_reps;
    logic [CONF_WIDTH-1:0] conf;
    logic [IdWidth-1:0]    next_id;
    logic [IdWidth-1:0]    done_id;

    logic [7:0]            reg_off;
    logic                  is_launch;
    logic                  reg_write;
    logic                  reg_read;
    logic                  push;
    logic [31:0]           rdata;
    logic                  rst_n;
    logic                  queue_full;
    logic                  queue_empty;
    logic [USAGE_W-1:0]    queue_usage;
    transf_descr_t         push_descr;
    logic                  unused_addr;

    assign reg_off     = ctrl_add_i[7:0];
    assign unused_addr = ^ctrl_add_i[31:8];
    assign is_launch   = (reg_off == OFF_LAUNCH);

    // Only a launch read can stall: it must have a free slot to push into
    assign ctrl_gnt_o = ctrl_req_i & ~(ctrl_type_i & is_launch & queue_full);

    assign reg_write = ctrl_req_i & ctrl_gnt_o & ~ctrl_type_i;
    assign reg_read  = ctrl_req_i & ctrl_gnt_o &  ctrl_type_i;
    assign push      = reg_read & is_launch & (num_bytes != 32'h0);

    // ------------------------------------------------------------------
    // Shadow registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            src_addr   <= '0;
            dst_addr   <= '0;
            num_bytes  <= '0;
            src_stride <= '0;
            dst_stride <= '0;
            num_reps   <= '0;
            conf       <= CONF_RESET;
        end else if (reg_write) begin
            case (reg_off)
                OFF_SRC_LO:     src_addr[31:0]  <= apply_be(src_addr[31:0], ctrl_data_i, ctrl_be_i);
                OFF_SRC_HI:     if (HAS_HI) src_addr[63:32] <= apply_be(src_addr[63:32], ctrl_data_i, ctrl_be_i);
                OFF_DST_LO:     dst_addr[31:0]  <= apply_be(dst_addr[31:0], ctrl_data_i, ctrl_be_i);
                OFF_DST_HI:     if (HAS_HI) dst_addr[63:32] <= apply_be(dst_addr[63:32], ctrl_data_i, ctrl_be_i);
                OFF_NUM_BYTES:  num_bytes  <= apply_be(num_bytes, ctrl_data_i, ctrl_be_i);
                OFF_CONF:       if (ctrl_be_i[0]) conf <= ctrl_data_i[CONF_WIDTH-1:0];
                OFF_SRC_STRIDE: src_stride <= apply_be(src_stride, ctrl_data_i, ctrl_be_i);
                OFF_DST_STRIDE: dst_stride <= apply_be(dst_stride, ctrl_data_i, ctrl_be_i);
                OFF_NUM_REPS:   num_reps   <= apply_be(num_reps, ctrl_data_i, ctrl_be_i);
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Transfer IDs: 0 is reserved as "no transfer", so both counters skip it
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            next_id <= ID_ONE;
            done_id <= '0;
        end else begin
            if (push)      next_id <= (next_id == ID_MAX) ? ID_ONE : next_id + ID_ONE;
            if (be_done_i) done_id <= (done_id == ID_MAX) ? ID_ONE : done_id + ID_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Read data mux
    // ------------------------------------------------------------------
    always_comb begin
        rdata = 32'h0;
        case (reg_off)
            OFF_SRC_LO:     rdata = src_addr[31:0];
            OFF_SRC_HI:     if (HAS_HI) rdata = src_addr[63:32];
            OFF_DST_LO:     rdata = dst_addr[31:0];
            OFF_DST_HI:     if (HAS_HI) rdata = dst_addr[63:32];
            OFF_NUM_BYTES:  rdata = num_bytes;
            OFF_CONF:       rdata = {{(32-CONF_WIDTH){1'b0}}, conf};
            OFF_SRC_STRIDE: rdata = src_stride;
            OFF_DST_STRIDE: rdata = dst_stride;
            OFF_NUM_REPS:   rdata = num_reps;
            OFF_LAUNCH:     rdata = (num_bytes != 32'h0) ? 32'(next_id) : 32'h0;
            // usage wraps to zero at full, hence the separate full flag
            OFF_STATUS:     rdata = {15'h0, be_busy_i, 7'h0, queue_full, 8'(queue_usage)};
            OFF_DONE_ID:    rdata = 32'(done_id);
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Registered response and interrupt
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ctrl_valid_o <= 1'b0;
            ctrl_data_o  <= 32'h0;
            irq_o        <= 1'b0;
        end else begin
            ctrl_valid_o <= ctrl_req_i & ctrl_gnt_o;
            ctrl_data_o  <= reg_read ? rdata : 32'h0;
            irq_o        <= be_done_i & conf[CONF_IRQ_EN];
        end
    end

    // ------------------------------------------------------------------
    // Descriptor queue
    // ------------------------------------------------------------------
    assign push_descr = transf_descr_t'(build_descr(src_addr, dst_addr, num_bytes,
                                                    src_stride, dst_stride, num_reps, conf));
    assign rst_n      = ~rst_i;
    assign be_valid_o = ~queue_empty;

    fifo_v3 #(
        .DEPTH (FifoDepth),
        .dtype (transf_descr_t)
    ) i_queue (
        .clk_i      (clk_i),
        .rst_ni     (rst_n),
        .flush_i    (1'b0),
        .testmode_i (1'b0),
        .full_o     (queue_full),
        .empty_o    (queue_empty),
        .usage_o    (queue_usage),
        .data_i     (push_descr),
        .push_i     (push),
        .data_o     (transf_descr_o),
        .pop_i      (be_ready_i)
    );

endmodule
`default_nettype wire

// File: tb/tb_cluster_dma_frontend_queue_regs.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cluster_dma_frontend_queue_regs
//  Purpose  : Self-checking bench: a register/queue model (array + queue of
//             descriptors) predicts grant, response, interrupt and queue head
//             every cycle; directed scenarios add literal expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cluster_dma_frontend_queue_regs;
    import cluster_dma_frontend_pkg::*;

    localparam int DEPTH  = 4;
    localparam int ID_MAX = 15;

    logic        clk, rst;
    logic        ctrl_req_i, ctrl_type_i;
    logic [3:0]  ctrl_be_i;
    logic [31:0] ctrl_add_i, ctrl_data_i;
    logic        ctrl_gnt_o, ctrl_valid_o;
    logic [31:0] ctrl_data_o;
    logic        be_valid_o, be_ready_i, be_busy_i, be_done_i, irq_o;
    dma_descr_t  transf_descr_o;

    int errors = 0;
    int checks = 0;

    // Model state
    logic [31:0] mreg [9];
    dma_descr_t  mq [$];
    int          next_id, done_id;
    logic [31:0] last_rd;
    logic        last_gnt;

    cluster_dma_frontend_queue_regs #(
        .transf_descr_t (dma_descr_t),
        .AddrWidth      (64),
        .FifoDepth      (DEPTH),
        .IdWidth        (4)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .ctrl_req_i     (ctrl_req_i),
        .ctrl_type_i    (ctrl_type_i),
        .ctrl_be_i      (ctrl_be_i),
        .ctrl_add_i     (ctrl_add_i),
        .ctrl_data_i    (ctrl_data_i),
        .ctrl_gnt_o     (ctrl_gnt_o),
        .ctrl_valid_o   (ctrl_valid_o),
        .ctrl_data_o    (ctrl_data_o),
        .be_valid_o     (be_valid_o),
        .be_ready_i     (be_ready_i),
        .transf_descr_o (transf_descr_o),
        .be_busy_i      (be_busy_i),
        .be_done_i      (be_done_i),
        .irq_o          (irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    function automatic void mreset();
        for (int i = 0; i < 9; i++) mreg[i] = 32'h0;
        mreg[5] = 32'h5;
        mq.delete();
        next_id = 1;
        done_id = 0;
    endfunction

    function automatic int id_next(input int id);
        return (id == ID_MAX) ? 1 : id + 1;
    endfunction

    function automatic dma_descr_t model_descr();
        dma_descr_t d;
        d.num_bytes  = mreg[4];
        d.src_addr   = {mreg[1], mreg[0]};
        d.dst_addr   = {mreg[3], mreg[2]};
        d.src_stride = mreg[6];
        d.dst_stride = mreg[7];
        d.num_reps   = mreg[8];
        d.is_2d      = (mreg[8] > 1);
        d.decouple   = mreg[5][0];
        d.deburst    = mreg[5][1];
        d.serialize  = mreg[5][2];
        return d;
    endfunction

    function automatic logic [31:0] model_read(input logic [7:0] off, input logic busy);
        if (off[1:0] == 2'b00 && off <= 8'h20) return mreg[int'(off >> 2)];
        if (off == 8'h28) return {15'h0, busy, 7'h0, (mq.size() == DEPTH), 8'(mq.size() % DEPTH)};
        if (off == 8'h2C) return 32'(done_id);
        return 32'h0;
    endfunction

    function automatic void model_write(input logic [7:0] off, input logic [3:0] be, input logic [31:0] wd);
        int idx;
        if (off[1:0] == 2'b00 && off <= 8'h20) begin
            idx = int'(off >> 2);
            for (int b = 0; b < 4; b++) if (be[b]) mreg[idx][b*8 +: 8] = wd[b*8 +: 8];
            if (idx == 5) mreg[5] = mreg[5] & 32'hF;
        end
    endfunction

    // One clock cycle: drive after a falling edge, check and predict before
    // the rising edge, update the model on it, check responses after it.
    task automatic cycle(input logic req, input logic typ, input logic [3:0] be,
                         input logic [31:0] add, input logic [31:0] wd,
                         input logic rdy, input logic busy, input logic done);
        logic [7:0]  off;
        logic        exp_gnt, do_push, do_pop, exp_irq, exp_rd;
        logic [31:0] rd;
        dma_descr_t  nd;
        ctrl_req_i = req; ctrl_type_i = typ; ctrl_be_i = be; ctrl_add_i = add;
        ctrl_data_i = wd; be_ready_i = rdy; be_busy_i = busy; be_done_i = done;
        #1;
        off     = add[7:0];
        exp_gnt = req && !(typ && off == 8'h24 && mq.size() == DEPTH);
        check("gnt", ctrl_gnt_o, exp_gnt);
        last_gnt = ctrl_gnt_o;
        check("be_valid", be_valid_o, mq.size() != 0);
        if (mq.size() != 0) begin
            checks++;
            if (transf_descr_o !== mq[0]) begin
                errors++;
                $display("FAIL descr: got %h required %h", transf_descr_o, mq[0]);
            end
        end
        rd      = model_read(off, busy);
        do_push = 1'b0;
        nd      = model_descr();
        exp_rd  = req && typ && exp_gnt;
        if (exp_rd && off == 8'h24) begin
            if (mreg[4] != 0) begin
                rd      = 32'(next_id);
                do_push = 1'b1;
            end else begin
                rd = 32'h0;
            end
        end
        do_pop  = rdy && mq.size() != 0;
        exp_irq = done && mreg[5][3];
        @(posedge clk);
        if (do_pop) void'(mq.pop_front());
        if (do_push) begin
            mq.push_back(nd);
            next_id = id_next(next_id);
        end
        if (req && !typ) model_write(off, be, wd);
        if (done) done_id = id_next(done_id);
        #1;
        check("ctrl_valid", ctrl_valid_o, req && exp_gnt);
        if (exp_rd) check("ctrl_data", ctrl_data_o, rd);
        check("irq", irq_o, exp_irq);
        last_rd = ctrl_data_o;
        @(negedge clk);
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] d);
        cycle(1'b1, 1'b0, 4'hF, {24'h0, off}, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rd(input logic [7:0] off, input logic rdy, input logic done);
        cycle(1'b1, 1'b1, 4'h0, {24'h0, off}, 32'h0, rdy, 1'b0, done);
    endtask

    task automatic idle(input logic rdy, input logic done);
        cycle(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, rdy, 1'b0, done);
    endtask

    // Reset is raised between clock edges to exercise its asynchronous path
    task automatic do_reset();
        ctrl_req_i = 0; ctrl_type_i = 0; ctrl_be_i = 0; ctrl_add_i = 0;
        ctrl_data_i = 0; be_ready_i = 0; be_busy_i = 0; be_done_i = 0;
        rst = 1'b1;
        #1;
        check("rst be_valid", be_valid_o, 1'b0);
        @(posedge clk);
        #1;
        check("rst ctrl_valid", ctrl_valid_o, 1'b0);
        check("rst irq", irq_o, 1'b0);
        mreset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int guard;
        rst = 1'b1;
        do_reset();

        // Basic launch
        wr(8'h00, 32'h1000_0000);
        wr(8'h08, 32'h1C00_0000);
        wr(8'h10, 32'd64);
        rd(8'h24, 1'b0, 1'b0);
        check("first launch id", last_rd, 1);
        check("first be_valid", be_valid_o, 1'b1);
        check("first src", transf_descr_o.src_addr, 64'h1000_0000);
        check("first dst", transf_descr_o.dst_addr, 64'h1C00_0000);
        check("first num_bytes", transf_descr_o.num_bytes, 64);
        check("first is_2d", transf_descr_o.is_2d, 1'b0);
        check("first decouple", transf_descr_o.decouple, 1'b1);

        // Zero-length launch consumes no ID
        wr(8'h10, 32'd0);
        rd(8'h24, 1'b0, 1'b0);
        check("zero launch rdata", last_rd, 0);
        wr(8'h10, 32'd64);
        rd(8'h24, 1'b0, 1'b0);
        check("after zero launch id", last_rd, 2);

        // 2D descriptor
        wr(8'h20, 32'd8);
        wr(8'h18, 32'h100);
        wr(8'h1C, 32'h200);
        rd(8'h24, 1'b0, 1'b0);
        check("2d launch id", last_rd, 3);
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b0);
        check("2d is_2d", transf_descr_o.is_2d, 1'b1);
        check("2d src_stride", transf_descr_o.src_stride, 32'h100);
        check("2d dst_stride", transf_descr_o.dst_stride, 32'h200);
        idle(1'b1, 1'b0);

        // Back-pressure at full queue
        do_reset();
        wr(8'h10, 32'd64);
        for (int i = 1; i <= 4; i++) begin
            rd(8'h24, 1'b0, 1'b0);
            check("fill launch id", last_rd, 64'(i));
        end
        rd(8'h24, 1'b0, 1'b0);
        check("held launch gnt", last_gnt, 1'b0);
        rd(8'h24, 1'b1, 1'b0);
        guard = 0;
        last_gnt = 1'b0;
        while (!last_gnt && guard < 4) begin
            rd(8'h24, 1'b0, 1'b0);
            guard++;
        end
        check("held launch granted", last_gnt, 1'b1);
        check("held launch id", last_rd, 5);
        rd(8'h28, 1'b0, 1'b0);
        check("status full", last_rd, 32'h100);

        // ID wrap and interrupt enable
        do_reset();
        wr(8'h10, 32'd16);
        wr(8'h14, 32'hD);
        for (int i = 1; i <= 16; i++) begin
            if (i == 9) wr(8'h14, 32'h5);
            rd(8'h24, 1'b1, 1'b0);
            check("wrap launch id", last_rd, (i <= ID_MAX) ? 64'(i) : 64'd1);
            idle(1'b1, 1'b1);
            if (i == 1)  check("irq enabled", irq_o, 1'b1);
            if (i == 16) check("irq disabled", irq_o, 1'b0);
        end
        rd(8'h2C, 1'b0, 1'b0);
        check("done_id wrapped", last_rd, 1);

        // Reset with entries queued
        wr(8'h10, 32'd64);
        for (int i = 0; i < 3; i++) rd(8'h24, 1'b0, 1'b0);
        check("three queued", be_valid_o, 1'b1);
        do_reset();
        rd(8'h28, 1'b0, 1'b0);
        check("status after reset", last_rd, 0);
        wr(8'h10, 32'd64);
        rd(8'h24, 1'b0, 1'b0);
        check("launch after reset", last_rd, 1);

        // Randomized traffic
        for (int n = 0; n < 2500; n++) begin
            int          r;
            logic [7:0]  off;
            logic [31:0] add;
            logic        typ;
            r = $urandom_range(0, 99);
            if (r < 35)      off = 8'h24;
            else if (r < 45) off = 8'($urandom_range(0, 255));
            else             off = 8'($urandom_range(0, 11) * 4);
            add = ($urandom() & 32'hFFFF_FF00) | 32'(off);
            typ = (off == 8'h24) ? ($urandom_range(0, 9) != 0) : 1'($urandom_range(0, 1));
            cycle($urandom_range(0, 3) != 0, typ, 4'($urandom()), add, $urandom(),
                  $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)), $urandom_range(0, 5) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
